// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-bus round-robin arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    // Read data returned to a master whose access was killed by the watchdog.
    localparam logic [15:0] ERR_READ_DATA = 16'hffff;

    // Width of a port index; never narrower than one bit.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotating priority encoder: returns the first unmasked requester after `last`.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    input  logic [NUM_PORTS-1:0] mask,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);

    logic [NUM_PORTS-1:0] elig;

    assign elig = req & ~mask;

    // Scan from last+1 around the ring; `last` itself is visited last.
    always_comb begin
        int p;
        valid = 1'b0;
        idx   = '0;
        p     = 0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            p = (int'(last) + off) % NUM_PORTS;
            if (!valid && elig[p]) begin
                valid = 1'b1;
                idx   = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// N-port round-robin arbiter for the 16-bit word-addressed memory bus.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no owner; any request is arbitrated and granted next edge
//   GRANT  | owner's access is forwarded downstream, waiting for ack
//   LOCKED | owner acked with m_lock high; bus held for its next access
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,

    input  logic [NUM_PORTS-1:0][19:1]  m_addr,
    input  logic [NUM_PORTS-1:0][15:0]  m_data_out,
    input  logic [NUM_PORTS-1:0]        m_wr_en,
    input  logic [NUM_PORTS-1:0][1:0]   m_bytesel,
    input  logic [NUM_PORTS-1:0]        m_access,
    input  logic [NUM_PORTS-1:0]        m_lock,
    output logic [NUM_PORTS-1:0]        m_ack,
    output logic [15:0]                 m_data_in,
    output logic                        m_error,

    output logic [19:1]                 q_m_addr,
    output logic [15:0]                 q_m_data_out,
    output logic                        q_m_wr_en,
    output logic [1:0]                  q_m_bytesel,
    output logic                        q_m_access,
    input  logic                        q_m_ack,
    input  logic [15:0]                 q_m_data_in
);

    localparam int IW     = port_idx_w(NUM_PORTS);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        last_winner;
    logic [CNT_W-1:0]     counter;

    logic                 in_grant;
    logic                 own_acc;
    logic                 violation;
    logic                 real_ack;
    logic                 tmo;
    logic                 ack_now;
    logic [NUM_PORTS-1:0] owner_mask;
    logic [IW-1:0]        pick_last;
    logic [NUM_PORTS-1:0] pick_mask;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;

    assign in_grant  = (state == GRANT);
    assign own_acc   = m_access[owner];
    // Owner withdrew its request before completion: drop it silently.
    assign violation = in_grant && !own_acc;
    assign real_ack  = in_grant && own_acc && q_m_ack;
    // A real ack in the same cycle beats the watchdog.
    assign tmo       = WD_EN && in_grant && own_acc && !q_m_ack && (counter == TMO_LAST);
    assign ack_now   = real_ack || tmo;

    // One-hot of the current owner, used to mask it during the ack cycle.
    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
    end

    // In GRANT the search rotates from the owner (it becomes last_winner on ack).
    assign pick_last = in_grant ? owner : last_winner;
    assign pick_mask = in_grant ? owner_mask : '0;

    mem_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IW)
    ) u_pick (
        .req   (m_access),
        .last  (pick_last),
        .mask  (pick_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Arbitration FSM: owner, rotation pointer and watchdog counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            last_winner <= IW'(NUM_PORTS - 1);
            counter     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick_idx;
                        counter <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (violation) begin
                        state <= IDLE;
                    end else if (real_ack && m_lock[owner]) begin
                        state <= LOCKED;
                    end else if (ack_now) begin
                        last_winner <= owner;
                        if (pick_valid) begin
                            owner   <= pick_idx;
                            counter <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (WD_EN) begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (own_acc) begin
                        counter <= '0;
                        state   <= GRANT;
                    end else if (!m_lock[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion pulse to the owner, from the downstream ack or the watchdog.
    always_comb begin
        m_ack = '0;
        if (ack_now) m_ack[owner] = 1'b1;
    end

    assign m_error      = tmo;
    assign m_data_in    = tmo ? ERR_READ_DATA : q_m_data_in;
    assign q_m_access   = in_grant && own_acc && !q_m_ack && !tmo;
    assign q_m_addr     = m_addr[owner];
    assign q_m_data_out = m_data_out[owner];
    assign q_m_wr_en    = m_wr_en[owner];
    assign q_m_bytesel  = m_bytesel[owner];

endmodule
